// File: rtl/wrap_pkg.sv
// Shared types and helpers for the wrapper boundary bank.
package wrap_pkg;

  // Per-edge shift-stage operation, decoded once and shared by every chain.
  typedef enum logic [1:0] {
    WBR_HOLD,
    WBR_SHIFT,
    WBR_CAPTURE
  } wbr_op_t;

  // Width of a counter that must hold the values 0..l.
  function automatic int wbr_cnt_w(input int l);
    return $clog2(l + 1);
  endfunction

endpackage

// File: rtl/wrapper_chain.sv
// One boundary scan chain: L-bit shift stage plus L-bit update stage.
// With WBR_BYPASS_EN defined, a 1-bit bypass flop can replace the chain on SO.
module wrapper_chain
  import wrap_pkg::*;
#(
  parameter int L = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  wbr_op_t       op,
  input  logic          upd_en,
  input  logic [L-1:0]  d,
  input  logic          si,
`ifdef WBR_BYPASS_EN
  input  logic          bypass,
`endif
  output logic          so,
  output logic [L-1:0]  upd_q
);

  logic [L-1:0] shift_q;
  logic [L-1:0] shift_nxt;
  logic         shift_hold;

`ifdef WBR_BYPASS_EN
  logic byp_q;
  assign shift_hold = bypass;
`else
  assign shift_hold = 1'b0;
`endif

  // Next shift value: bits move toward index 0, SI enters the top bit.
  always_comb begin
    shift_nxt        = shift_q >> 1;
    shift_nxt[L-1]   = si;
  end

  // Shift stage: shift has priority over capture; bypass freezes the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      case (op)
        WBR_SHIFT:   if (!shift_hold) shift_q <= shift_nxt;
        WBR_CAPTURE: shift_q <= d;
        default:     ;
      endcase
    end
  end

  // Update stage: takes the pre-edge shift value when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= '0;
    end else if (upd_en) begin
      upd_q <= shift_q;
    end
  end

`ifdef WBR_BYPASS_EN
  // Bypass flop: one-bit scan path used while bypass is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else if (op == WBR_SHIFT && bypass) begin
      byp_q <= si;
    end
  end

  assign so = bypass ? byp_q : shift_q[0];
`else
  assign so = shift_q[0];
`endif

endmodule

// File: rtl/wrapper_boundary_bank.sv
// Bank of scan-wrapper boundary cells organised as CHAINS parallel chains.
// Optional feature macro: WBR_BYPASS_EN (adds BYPASS input and per-chain bypass flops).
module wrapper_boundary_bank
  import wrap_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 1
) (
  input  logic                                  CK,
  input  logic                                  RN,
  input  logic [WIDTH-1:0]                      D,
  output logic [WIDTH-1:0]                      Q,
  input  logic                                  TEST_MODE,
  input  logic                                  SE,
  input  logic                                  CAPTURE,
  input  logic                                  UPDATE,
  input  logic [CHAINS-1:0]                     SI,
  output logic [CHAINS-1:0]                     SO,
`ifdef WBR_BYPASS_EN
  input  logic                                  BYPASS,
`endif
  output logic [wbr_cnt_w(WIDTH/CHAINS)-1:0]    SHIFT_CNT,
  output logic                                  SHIFT_DONE
);

  localparam int L  = WIDTH / CHAINS;
  localparam int CW = wbr_cnt_w(L);
  localparam logic [CW-1:0] CNT_MAX = CW'(L);

  if (WIDTH % CHAINS != 0) begin : g_bad_cfg
    $error("wrapper_boundary_bank: WIDTH must be a multiple of CHAINS");
  end

  wbr_op_t         op;
  logic            upd_en;
  logic            cnt_adv;
  logic [WIDTH-1:0] upd;

  // Operation decode shared by all chains: SE beats CAPTURE.
  always_comb begin
    op = WBR_HOLD;
    if (SE)           op = WBR_SHIFT;
    else if (CAPTURE) op = WBR_CAPTURE;
  end

  assign upd_en = UPDATE & ~SE;

`ifdef WBR_BYPASS_EN
  assign cnt_adv = (op == WBR_SHIFT) & ~BYPASS;
`else
  assign cnt_adv = (op == WBR_SHIFT);
`endif

  // Shift counter: counts shift edges since capture, saturating at L.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      SHIFT_CNT <= '0;
    end else if (cnt_adv) begin
      if (SHIFT_CNT != CNT_MAX) SHIFT_CNT <= SHIFT_CNT + 1'b1;
    end else if (op == WBR_CAPTURE) begin
      SHIFT_CNT <= '0;
    end
  end

  assign SHIFT_DONE = (SHIFT_CNT == CNT_MAX);

  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    wrapper_chain #(
      .L(L)
    ) u_chain (
      .clk    (CK),
      .rst_n  (RN),
      .op     (op),
      .upd_en (upd_en),
      .d      (D[c*L +: L]),
      .si     (SI[c]),
`ifdef WBR_BYPASS_EN
      .bypass (BYPASS),
`endif
      .so     (SO[c]),
      .upd_q  (upd[c*L +: L])
    );
  end

  assign Q = TEST_MODE ? upd : D;

endmodule
